// File: rtl/i2c_pkg.sv
// Shared constants and FSM encoding for the I2C transaction arbiter.
package i2c_pkg;

    localparam int MAX_N_REQ       = 8;
    localparam int IDX_W           = $clog2(MAX_N_REQ);
    localparam int DEF_N_REQ       = 4;
    localparam int DEF_TIMEOUT_CYC = 256;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_COMPLETE
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest set index above last_idx,
// otherwise the lowest set index overall.
module rr_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_idx,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic             hi_v;
    logic [IDX_W-1:0] hi_i;
    logic [IDX_W-1:0] lo_i;

    always_comb begin
        hi_v = 1'b0;
        hi_i = '0;
        lo_i = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_i = IDX_W'(j);
                if (j > int'(last_idx)) begin
                    hi_v = 1'b1;
                    hi_i = IDX_W'(j);
                end
            end
        end
        valid = |req;
        idx   = hi_v ? hi_i : lo_i;
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Arbitrates byte transactions from N_REQ requesters onto one I2C byte
// master, with per-transaction completion timeout.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ack,
    output logic [N_REQ-1:0]   req_err,
    output logic               m_start,
    output logic [7:0]         m_data,
    input  logic               m_done,
    output logic               busy,
    output logic [IDX_W-1:0]   gnt_idx
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic [IDX_W-1:0] last_gnt;

    logic             rr_valid;
    logic [IDX_W-1:0] rr_idx;
    logic [7:0]       sel_byte;
    logic [N_REQ-1:0] gnt_oh;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rr (
        .req     (req_valid),
        .last_idx(last_gnt),
        .valid   (rr_valid),
        .idx     (rr_idx)
    );

    always_comb begin
        sel_byte = '0;
        gnt_oh   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (rr_idx == IDX_W'(j))
                sel_byte = req_data[8*j +: 8];
            if (gnt_idx == IDX_W'(j))
                gnt_oh[j] = 1'b1;
        end
    end

    assign busy    = (state != ST_IDLE);
    // err is only meaningful while the ack pulse is up
    assign req_err = req_ack & {N_REQ{err}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            m_start  <= 1'b0;
            m_data   <= '0;
            req_ack  <= '0;
            gnt_idx  <= '0;
            last_gnt <= IDX_LAST;
            cnt      <= '0;
            err      <= 1'b0;
        end else begin
            m_start <= 1'b0;
            req_ack <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (rr_valid) begin
                        gnt_idx  <= rr_idx;
                        last_gnt <= rr_idx;
                        m_data   <= sel_byte;
                        m_start  <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // done beats a timeout landing on the same cycle
                    if (m_done) begin
                        err     <= 1'b0;
                        req_ack <= gnt_oh;
                        state   <= ST_COMPLETE;
                    end else if (cnt == CNT_LAST) begin
                        err     <= 1'b1;
                        req_ack <= gnt_oh;
                        state   <= ST_COMPLETE;
                    end else if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_COMPLETE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench: dut_a uses the default timeout, dut_t uses TIMEOUT_CYC=16.
module tb_i2c_txn_arbiter;
    import i2c_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic        m_done;

    logic [3:0]  a_ack, a_err, t_ack, t_err;
    logic        a_start, t_start, a_busy, t_busy;
    logic [7:0]  a_data, t_data;
    logic [2:0]  a_gnt, t_gnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    i2c_txn_arbiter #(.N_REQ(4), .TIMEOUT_CYC(256)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data),
        .req_ack(a_ack), .req_err(a_err),
        .m_start(a_start), .m_data(a_data), .m_done(m_done),
        .busy(a_busy), .gnt_idx(a_gnt)
    );

    i2c_txn_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16)) dut_t (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data),
        .req_ack(t_ack), .req_err(t_err),
        .m_start(t_start), .m_data(t_data), .m_done(m_done),
        .busy(t_busy), .gnt_idx(t_gnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [2:0] exp_gnt;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        m_done    = 1'b0;
        ticks(3);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_ack", 32'(a_ack), 0);
        check("rst_start", 32'(a_start), 0);
        check("rst_gnt", 32'(a_gnt), 0);
        rst = 1'b0;
        tick();

        // spurious done in idle
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
        check("sp_busy", 32'(a_busy), 0);
        check("sp_ack", 32'(a_ack), 0);
        check("sp_err", 32'(a_err), 0);
        check("sp_start", 32'(a_start), 0);
        check("sp_data", 32'(a_data), 0);
        check("sp_gnt", 32'(a_gnt), 0);

        // single request, done 20 cycles after start
        req_data  = 32'h0000_A500;
        req_valid = 4'b0010;
        tick();
        check("s_start", 32'(a_start), 1);
        check("s_data", 32'(a_data), 32'hA5);
        check("s_gnt", 32'(a_gnt), 1);
        check("s_busy", 32'(a_busy), 1);
        tick();
        check("s_start_1cyc", 32'(a_start), 0);
        ticks(19);
        check("s_data_hold", 32'(a_data), 32'hA5);
        check("s_no_ack_yet", 32'(a_ack), 0);
        m_done = 1'b1;
        tick();
        m_done    = 1'b0;
        req_valid = 4'b0000;
        check("s_ack", 32'(a_ack), 32'b0010);
        check("s_err", 32'(a_err), 0);
        tick();
        check("s_ack_pulse", 32'(a_ack), 0);
        check("s_idle", 32'(a_busy), 0);

        // round-robin with all requesters held
        do_reset();
        req_data  = 32'h1312_1110;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 3'(k % 4);
            tick();
            check($sformatf("rr_gnt%0d", k), 32'(a_gnt), 32'(exp_gnt));
            check($sformatf("rr_start%0d", k), 32'(a_start), 1);
            check($sformatf("rr_data%0d", k), 32'(a_data),
                  32'h10 + 32'(exp_gnt));
            tick();
            m_done = 1'b1;
            tick();
            m_done = 1'b0;
            check($sformatf("rr_ack%0d", k), 32'(a_ack),
                  32'(4'b0001 << exp_gnt));
            if (k == 4) req_valid = 4'b0000;
            tick();
        end
        check("rr_idle", 32'(a_busy), 0);

        // reset while waiting for done
        req_valid = 4'b0001;
        tick();
        check("rw_gnt0", 32'(a_gnt), 0);
        req_valid = 4'b0011;
        ticks(3);
        check("rw_busy_pre", 32'(a_busy), 1);
        rst = 1'b1;
        #1;
        check("rw_busy_rst", 32'(a_busy), 0);
        check("rw_ack_rst", 32'(a_ack), 0);
        tick();
        rst = 1'b0;
        check("rw_ack_rel", 32'(a_ack), 0);
        tick();
        check("rw_regnt", 32'(a_gnt), 0);
        check("rw_start", 32'(a_start), 1);
        tick();
        m_done = 1'b1;
        tick();
        m_done    = 1'b0;
        req_valid = 4'b0000;
        check("rw_ack", 32'(a_ack), 32'b0001);
        tick();

        // timeout on the short-timeout instance
        do_reset();
        req_valid = 4'b0100;
        tick();
        check("to_start", 32'(t_start), 1);
        check("to_gnt", 32'(t_gnt), 2);
        ticks(16);
        check("to_no_ack16", 32'(t_ack), 0);
        tick();
        req_valid = 4'b0000;
        check("to_ack17", 32'(t_ack), 32'b0100);
        check("to_err17", 32'(t_err), 32'b0100);
        tick();
        check("to_ack_pulse", 32'(t_ack), 0);
        check("to_err_pulse", 32'(t_err), 0);
        check("to_idle", 32'(t_busy), 0);

        // done coincident with the timeout cycle
        req_valid = 4'b1000;
        tick();
        check("co_gnt", 32'(t_gnt), 3);
        ticks(16);
        m_done = 1'b1;
        tick();
        m_done    = 1'b0;
        req_valid = 4'b0000;
        check("co_ack", 32'(t_ack), 32'b1000);
        check("co_err", 32'(t_err), 0);
        tick();
        check("co_idle", 32'(t_busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_txn_arbiter.md
I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 256, giving the maximum cycles to wait for m_done per transaction (≥4).
REQ-003 The block SHALL have one clock and an asynchronous active-high reset, ports as follows:
  clk          in   1        system clock, all logic on rising edge
  rst          in   1        asynchronous, active-high reset
  req_valid    in   N_REQ    per-requester transaction request, held until acked
  req_data     in   8*N_REQ  byte per requester, slice i = [8i+7:8i]
  req_ack      out  N_REQ    one-cycle completion pulse to granted requester
  req_err      out  N_REQ    one-cycle timeout flag, coincident with req_ack
  m_start      out  1        one-cycle start pulse to I2C byte master
  m_data       out  8        byte to I2C byte master
  m_done       in   1        completion pulse from I2C byte master
  busy         out  1        high whenever state is not IDLE
  gnt_idx      out  3        index of current/last granted requester

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE and COMPLETE.
REQ-005 In IDLE with any req_valid bit set, the block SHALL select a requester round-robin, register gnt_idx and m_data from req_data[gnt_idx], and go to ISSUE next cycle.
REQ-006 Round-robin SHALL search from the index (last_gnt+1) mod N_REQ upward with wrap-around; after reset the search SHALL start at index 0.
REQ-007 In ISSUE, m_start SHALL be 1 for exactly that one cycle, and the next state SHALL be WAIT_DONE with the timeout counter cleared to 0.
REQ-008 m_data SHALL remain stable from ISSUE until the return to IDLE.
REQ-009 In WAIT_DONE, m_done=1 SHALL transition the FSM to COMPLETE with the err flag cleared.
REQ-010 In WAIT_DONE, the counter SHALL increment each cycle; when it reaches TIMEOUT_CYC-1 without m_done, the FSM SHALL go to COMPLETE with the err flag set.
REQ-011 If m_done and the timeout coincide in the same cycle, m_done SHALL win (no error).
REQ-012 In COMPLETE, req_ack[gnt_idx]=1 and req_err[gnt_idx]=err for one cycle, then the FSM SHALL return to IDLE; all other ack/err bits SHALL be 0.
REQ-013 Latency SHALL be: request sampled in IDLE at cycle t gives m_start at t+1; m_done at cycle d gives req_ack at d+1.
REQ-014 m_done outside WAIT_DONE SHALL be ignored.
REQ-015 req_valid deasserting after grant SHALL NOT abort the transaction; ack SHALL still be pulsed.
REQ-016 A requester SHALL NOT be re-granted in the IDLE cycle following its own ack when another req_valid is set (fairness via REQ-006).
REQ-017 busy SHALL be combinationally equal to (state != IDLE).
REQ-018 The counter width SHALL be $clog2(TIMEOUT_CYC+1) bits, and the counter SHALL saturate rather than wrap.

Reset
REQ-019 On rst, the block SHALL force state=IDLE, m_start=0, m_data=0, req_ack=0, req_err=0, gnt_idx=0, last_gnt=N_REQ-1, counter=0, err=0.
REQ-020 Reset asserted mid-transaction SHALL abort the transaction immediately with no ack pulse; after release the block SHALL resume in IDLE.

Structure
REQ-021 State encoding and default constants (TIMEOUT_CYC default, max N_REQ) SHALL live in shared package i2c_pkg.
REQ-022 The round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector and last index; outputs valid and index), combinational only.

Verification
REQ-023 Single request: req_valid=4'b0010, data1=8'hA5; m_done 20 cycles after m_start -> m_start at t+1, m_data=8'hA5, req_ack=4'b0010 one cycle after m_done, req_err=0.
REQ-024 Round-robin: req_valid=4'b1111 held, each m_done returned promptly -> grant order 0,1,2,3,0.
REQ-025 Timeout: TIMEOUT_CYC=16, m_done never asserted -> req_ack and req_err for the granted requester exactly 17 cycles after m_start.
REQ-026 Coincidence: m_done asserted on the timeout cycle -> req_ack=1, req_err=0.
REQ-027 Reset in WAIT_DONE: assert rst for 1 cycle -> no req_ack, busy=0, the next grant starts from index 0.
REQ-028 Spurious done: m_done pulsed in IDLE with no requests -> no state change, all outputs at reset values.
